iter_multiplier: RTL and testbench

//  Iterative shift-and-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops in the execute stage.

---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_sign_fix.sv | 19 +
 rtl/iter_multiplier.sv | 131 +++++++++++++
 tb/tb_iter_multiplier.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared opcode and state encodings for the iterative RV32M multiplier.
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mul_sign_fix.sv
// Splits an operand into an unsigned magnitude and a sign bit when it is treated as signed.
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] operand,
  input  logic         signed_flag,
  output logic [n-1:0] magnitude,
  output logic         sign
);

  localparam logic [n-1:0] ONE = n'(1);

  // The most negative value negates to itself, which read as unsigned is its true magnitude.
  assign sign      = signed_flag & operand[n-1];
  assign magnitude = sign ? ((~operand) + ONE) : operand;

endmodule

// File: rtl/iter_multiplier.sv
// Iterative shift-and-add multiplier, one multiplier bit per cycle (n cycles in RUN).
// Macro ITER_MULTIPLIER_MULH_EN enables MULH/MULHSU/MULHU; without it every op returns the unsigned low word.
module iter_multiplier
  import mul_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         valid,
  output logic [n-1:0] result
);

`ifdef ITER_MULTIPLIER_MULH_EN
  localparam int AW = 2 * n;
`else
  // Only the low word is ever returned, so the upper accumulator half would be dead logic.
  localparam int AW = n;
`endif
  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] acc_reg;
  logic [AW-1:0] mcand_reg;
  logic [AW-1:0] acc_sum;
  logic [n-1:0]  mplier_reg;
  logic [n-1:0]  result_reg;
  logic [n-1:0]  result_next;
  logic [n-1:0]  a_mag;
  logic [n-1:0]  b_mag;
  logic          a_signed;
  logic          b_signed;
  logic          a_neg;
  logic          b_neg;

  mul_sign_fix #(.n(n)) u_fix_a (
    .operand     (a),
    .signed_flag (a_signed),
    .magnitude   (a_mag),
    .sign        (a_neg)
  );

  mul_sign_fix #(.n(n)) u_fix_b (
    .operand     (b),
    .signed_flag (b_signed),
    .magnitude   (b_mag),
    .sign        (b_neg)
  );

  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

`ifdef ITER_MULTIPLIER_MULH_EN
  localparam logic [AW-1:0] ACC_ONE = AW'(1);

  logic          neg_reg;
  logic          hi_reg;
  logic [AW-1:0] acc_fixed;

  assign a_signed    = (op == OP_MULH) || (op == OP_MULHSU);
  assign b_signed    = (op == OP_MULH);
  // Sign fix is folded into the final RUN step so result is already loaded when valid rises.
  assign acc_fixed   = neg_reg ? ((~acc_sum) + ACC_ONE) : acc_sum;
  assign result_next = hi_reg ? acc_fixed[AW-1:n] : acc_fixed[n-1:0];
`else
  logic unused_sign;

  assign a_signed    = 1'b0;
  assign b_signed    = 1'b0;
  assign unused_sign = a_neg ^ b_neg ^ (^op);
  assign result_next = acc_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      result_reg <= '0;
`ifdef ITER_MULTIPLIER_MULH_EN
      neg_reg    <= 1'b0;
      hi_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg  <= S_RUN;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= AW'(a_mag);
            mplier_reg <= b_mag;
`ifdef ITER_MULTIPLIER_MULH_EN
            neg_reg    <= a_neg ^ b_neg;
            hi_reg     <= (op != OP_MUL);
`endif
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_reg    <= acc_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) begin
            state_reg  <= S_DONE;
            result_reg <= result_next;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ready  = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign busy   = (state_reg == S_RUN);
  assign valid  = (state_reg == S_DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier (n=32); expectations follow ITER_MULTIPLIER_MULH_EN.
module tb_iter_multiplier;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         ready;
  logic         busy;
  logic         valid;
  logic [N-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  iter_multiplier #(.n(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 40) $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Architectural product from exact 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [N-1:0] model_product(input logic [1:0] o, input logic [N-1:0] x,
                                                 input logic [N-1:0] y);
    logic [2*N-1:0] xe;
    logic [2*N-1:0] ye;
    logic [2*N-1:0] p;
`ifdef ITER_MULTIPLIER_MULH_EN
    xe = (o == 2'b01 || o == 2'b10) ? {{N{x[N-1]}}, x} : {{N{1'b0}}, x};
    ye = (o == 2'b01) ? {{N{y[N-1]}}, y} : {{N{1'b0}}, y};
    p  = xe * ye;
    return (o == 2'b00) ? p[N-1:0] : p[2*N-1:N];
`else
    xe = {{N{1'b0}}, x};
    ye = {{N{1'b0}}, y};
    p  = xe * ye;
    return (o == 2'b00 || o != 2'b00) ? p[N-1:0] : '0;
`endif
  endfunction

  // Time-based model: an accepted request at edge e yields valid in the cycle after edge e+N.
  int unsigned  cyc = 0;
  int unsigned  vedge = 0;
  logic         pend = 1'b0;
  logic         m_init = 1'b0;
  logic [N-1:0] m_val = '0;
  logic [N-1:0] m_res = '0;

  always @(posedge clk) begin
    logic was_ready;
    cyc = cyc + 1;
    if (rst) begin
      pend   = 1'b0;
      m_res  = '0;
      m_init = 1'b1;
    end else begin
      if (pend && cyc == vedge) m_res = m_val;
      was_ready = !pend || ((cyc - 1) >= vedge);
      if (start && was_ready) begin
        pend  = 1'b1;
        vedge = cyc + N;
        m_val = model_product(op, a, b);
      end
    end
  end

  always @(negedge clk) begin
    logic e_busy;
    logic e_valid;
    if (m_init) begin
      e_busy  = pend && (cyc < vedge);
      e_valid = pend && (cyc == vedge);
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("ready", {31'd0, ready}, {31'd0, !e_busy});
      chk("valid", {31'd0, valid}, {31'd0, e_valid});
      chk("result", result, m_res);
    end
  end

  task automatic drive(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  task automatic wait_valid(input int inject, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (lat == 1) begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
      end
      if (inject != 0 && lat == inject) drive(2'b00, 32'd3, 32'd3);
      if (inject != 0 && lat == inject + 1) start = 1'b0;
      if (valid) break;
      if (lat >= 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: no valid after %0d cycles, want 33", lat);
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [N-1:0] x,
                        input logic [N-1:0] y, input logic [N-1:0] e_en, input logic [N-1:0] e_dis,
                        input int inject, input int gap);
    logic [N-1:0] e;
    int lat;
    int bc;
`ifdef ITER_MULTIPLIER_MULH_EN
    e = e_en;
`else
    e = e_dis;
`endif
    chk({name, " model"}, model_product(o, x, y), e);
    repeat (gap) @(negedge clk);
    drive(o, x, y);
    wait_valid(inject, lat, bc);
    chk({name, " result"}, result, e);
    chk({name, " latency"}, lat, 33);
    chk({name, " busy cycles"}, bc, 32);
    $display("op %-10s op=%b a=%h b=%h -> result=%h (want %h) latency=%0d busy=%0d",
             name, o, x, y, result, e, lat, bc);
  endtask

  initial begin
    int vcount;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset result", result, 32'd0);
    $display("reset released: ready=%b busy=%b valid=%b result=%h", ready, busy, valid, result);

    run_op("mul3x5",    2'b00, 32'd3,         32'd5,         32'h0000000F, 32'h0000000F, 0, 1);
    run_op("mulh_m1",   2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 32'h00000001, 0, 2);
    run_op("mul_m1",    2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 32'h00000001, 0, 2);
    run_op("mulhu_m1",  2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001, 0, 2);
    run_op("mulhsu",    2'b10, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF, 32'hFFFFFFFE, 0, 2);
    run_op("mulh_min",  2'b01, 32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000, 0, 2);
    run_op("mulh_neg",  2'b01, 32'hFFFFFFFB,  32'h00000007,  32'hFFFFFFFF, 32'hFFFFFFDD, 0, 2);
    run_op("mulh_zero", 2'b01, 32'h00000000,  32'h80000000,  32'h00000000, 32'h00000000, 0, 2);
    run_op("ignore",    2'b11, 32'h12345678,  32'h00000100,  32'h00000012, 32'h34567800, 10, 2);
    run_op("b2b",       2'b01, 32'hFFFFFFFE,  32'h00000003,  32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);

    // Abandon an operation with a reset in the middle of RUN.
    repeat (2) @(negedge clk);
    drive(2'b00, 32'h0000FFFF, 32'h0000FFFF);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun rst ready", {31'd0, ready}, 32'd1);
    chk("midrun rst valid", {31'd0, valid}, 32'd0);
    chk("midrun rst result", result, 32'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("abandoned op valid count", vcount, 0);
    $display("reset mid-run: valid pulses afterwards=%0d", vcount);

    run_op("mul7x6",    2'b00, 32'd7,         32'd6,         32'h0000002A, 32'h0000002A, 0, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
